tempavg_ctrl: RTL and testbench

- Sequencing controller for the shared 9-bit serial restoring divider in the temperature-averaging path.
- Accepts sensor samples over a valid/ready handshake and accumulates a window of samples.
- Launches the divider with sum/count, captures the quotient on the divider's done pulse, and holds the average until the consumer acknowledges it.
- Guards against a non-responding divider with a timeout.

---
 rtl/tempavg_ctrl.sv | 148 ++++++++++++++
 tb/tb_tempavg_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempavg_ctrl.sv
// Temperature-averaging sequencer: accumulates a sample window, drives the
// shared serial divider, and holds the average until the consumer acks it.
module tempavg_ctrl #(
  parameter int SAMPLE_W = 6,
  parameter int NSAMP    = 8,
  parameter int ROUND    = 1,
  parameter int TIMEOUT  = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                samp_valid_i,
  input  logic [SAMPLE_W-1:0] samp_data_i,
  output logic                samp_ready_o,
  input  logic                flush_i,
  output logic [8:0]          div_dividend_o,
  output logic [8:0]          div_divider_o,
  output logic                div_start_o,
  input  logic                div_ready_i,
  input  logic [8:0]          div_quotient_i,
  output logic                avg_valid_o,
  output logic [8:0]          avg_data_o,
  output logic [3:0]          avg_count_o,
  input  logic                avg_ack_i,
  output logic                err_timeout_o,
  output logic                busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ACC,
    S_LAUNCH,
    S_ARM,
    S_BUSY,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    sum_q, sum_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [8:0]    avg_q, avg_d;
  logic [3:0]    acnt_q, acnt_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  logic [9:0]    sum_ext;
  logic [3:0]    cnt_inc;
  logic [8:0]    rnd;
  logic          tmo;
  logic          launch;

  assign sum_ext = {1'b0, sum_q} + 10'(samp_data_i);
  assign cnt_inc = cnt_q + 4'd1;
  assign tmo     = (tmr_q == TW'(TIMEOUT));
  assign rnd     = (ROUND != 0) ? {6'b0, cnt_q[3:1]} : 9'd0;
  assign launch  = (state_q == S_LAUNCH);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    avg_d   = avg_q;
    acnt_d  = acnt_q;
    vld_d   = vld_q;
    err_d   = err_q;
    unique case (state_q)
      S_ACC: begin
        if (samp_valid_i) begin
          sum_d = sum_ext[9] ? 9'h1FF : sum_ext[8:0];
          cnt_d = cnt_inc;
        end
        if ((samp_valid_i && cnt_inc == 4'(NSAMP)) ||
            (flush_i && (samp_valid_i || cnt_q != 4'd0))) begin
          state_d = S_LAUNCH;
          tmr_d   = '0;
        end
      end
      S_LAUNCH, S_ARM, S_BUSY: begin
        tmr_d = tmr_q + TW'(1);
        if (tmo) begin
          err_d   = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
          state_d = S_ACC;
        end else begin
          unique case (state_q)
            S_LAUNCH: if (div_ready_i) state_d = S_ARM;
            // ready seen here is left over from the launch handshake
            S_ARM:    state_d = S_BUSY;
            default: begin
              if (div_ready_i) begin
                avg_d   = div_quotient_i;
                acnt_d  = cnt_q;
                vld_d   = 1'b1;
                state_d = S_HOLD;
              end
            end
          endcase
        end
      end
      S_HOLD: begin
        if (avg_ack_i) begin
          vld_d   = 1'b0;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      sum_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      avg_q   <= '0;
      acnt_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      avg_q   <= avg_d;
      acnt_q  <= acnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign samp_ready_o   = (state_q == S_ACC);
  assign busy_o         = (state_q != S_ACC);
  assign div_start_o    = launch;
  assign div_dividend_o = launch ? sum_q + rnd : 9'd0;
  assign div_divider_o  = launch ? {5'b0, cnt_q} : 9'd0;
  assign avg_valid_o    = vld_q;
  assign avg_data_o     = avg_q;
  assign avg_count_o    = acnt_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_tempavg_ctrl.sv
// Directed bench: two controllers (truncate / round) share stimulus and a
// behavioural serial-divider model with selectable ready behaviour.
module tb_tempavg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       samp_valid;
  logic [5:0] samp_data;
  logic       flush;
  logic       avg_ack;
  logic       drdy = 1'b0;
  logic [8:0] dq0 = 9'h1FF;
  logic [8:0] dq1 = 9'h1FF;

  logic       srdy0, srdy1, ds0, ds1, av0, av1;
  logic       err0, err1, bsy0, bsy1;
  logic [8:0] dvd0, dvd1, dvs0, dvs1, ad0, ad1;
  logic [3:0] ac0, ac1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tempavg_ctrl #(.SAMPLE_W(6), .NSAMP(4), .ROUND(0), .TIMEOUT(48)) u0 (
    .clk(clk), .rst(rst),
    .samp_valid_i(samp_valid), .samp_data_i(samp_data),
    .samp_ready_o(srdy0), .flush_i(flush),
    .div_dividend_o(dvd0), .div_divider_o(dvs0),
    .div_start_o(ds0), .div_ready_i(drdy), .div_quotient_i(dq0),
    .avg_valid_o(av0), .avg_data_o(ad0), .avg_count_o(ac0),
    .avg_ack_i(avg_ack), .err_timeout_o(err0), .busy_o(bsy0)
  );

  tempavg_ctrl #(.SAMPLE_W(6), .NSAMP(4), .ROUND(1), .TIMEOUT(48)) u1 (
    .clk(clk), .rst(rst),
    .samp_valid_i(samp_valid), .samp_data_i(samp_data),
    .samp_ready_o(srdy1), .flush_i(flush),
    .div_dividend_o(dvd1), .div_divider_o(dvs1),
    .div_start_o(ds1), .div_ready_i(drdy), .div_quotient_i(dq1),
    .avg_valid_o(av1), .avg_data_o(ad1), .avg_count_o(ac1),
    .avg_ack_i(avg_ack), .err_timeout_o(err1), .busy_o(bsy1)
  );

  // divider model: 0 = ready held while idle, 1 = idle pulse every 32, 2 = dead
  int         dmode = 0;
  logic [3:0] dcnt = 4'd0;
  logic [4:0] gap = 5'd0;
  logic [8:0] l0a = 9'd0, l0b = 9'd1, l1a = 9'd0, l1b = 9'd1;

  always_ff @(posedge clk) begin
    if (dcnt != 4'd0) begin
      dcnt <= dcnt - 4'd1;
      if (dcnt == 4'd1) begin
        drdy <= 1'b1;
        dq0  <= (l0b != 0) ? l0a / l0b : 9'd0;
        dq1  <= (l1b != 0) ? l1a / l1b : 9'd0;
      end else begin
        drdy <= 1'b0;
      end
    end else if (drdy && (ds0 || ds1)) begin
      dcnt <= 4'd9;
      drdy <= 1'b0;
      l0a  <= dvd0;
      l0b  <= dvs0;
      l1a  <= dvd1;
      l1b  <= dvs1;
      dq0  <= 9'h1FF;
      dq1  <= 9'h1FF;
    end else begin
      dq0  <= 9'h1FF;
      dq1  <= 9'h1FF;
      gap  <= gap + 5'd1;
      drdy <= (dmode == 0) || (dmode == 1 && gap == 5'd30);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d);
    samp_valid = 1'b1;
    samp_data  = d;
    tick();
    samp_valid = 1'b0;
  endtask

  task automatic wait_avg(output int n);
    n = 0;
    while (!av0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    avg_ack = 1'b1;
    tick();
    avg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nvec++;
    if ({srdy0, av0, err0, bsy0, ds0, ad0, ac0, dvd0, dvs0} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 9'd0, 9'd0}) begin
      nerr++;
      $display("FAIL reset u0: rdy=%b av=%b err=%b busy=%b st=%b ad=%0d ac=%0d want rdy=1 rest 0",
               srdy0, av0, err0, bsy0, ds0, ad0, ac0);
    end
    nvec++;
    if ({srdy1, av1, err1, bsy1, ds1, ad1, ac1} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 4'd0}) begin
      nerr++;
      $display("FAIL reset u1: rdy=%b av=%b err=%b busy=%b st=%b want rdy=1 rest 0",
               srdy1, av1, err1, bsy1, ds1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    tick();
    tick();
    push(6'd10);
    push(6'd20);
    push(6'd30);
    push(6'd43);
    nvec++;
    if ({ds0, srdy0, bsy0, dvd0, dvs0, dvd1} !==
        {1'b1, 1'b0, 1'b1, 9'd103, 9'd4, 9'd105}) begin
      nerr++;
      $display("FAIL launch operands: st=%b rdy=%b dvd0=%0d dvs0=%0d dvd1=%0d want 1 0 103 4 105",
               ds0, srdy0, dvd0, dvs0, dvd1);
    end
    wait_avg(n);
    nvec++;
    if (n !== 11) begin
      nerr++;
      $display("FAIL latency: avg_valid after %0d edges, want 11", n);
    end
    nvec++;
    if ({ad0, ac0, ad1, ac1, av1} !== {9'd25, 4'd4, 9'd26, 4'd4, 1'b1}) begin
      nerr++;
      $display("FAIL avg 4-sample: ad0=%0d ac0=%0d ad1=%0d ac1=%0d want 25 4 26 4",
               ad0, ac0, ad1, ac1);
    end
    ack();
    nvec++;
    if ({av0, srdy0, bsy0} !== 3'b010) begin
      nerr++;
      $display("FAIL ack: av=%b rdy=%b busy=%b want 0 1 0", av0, srdy0, bsy0);
    end
  endtask

  task automatic test_flush();
    int n;
    push(6'd5);
    push(6'd7);
    flush = 1'b1;
    push(6'd9);
    flush = 1'b0;
    nvec++;
    if ({ds0, dvd0, dvs0, dvd1, dvs1} !== {1'b1, 9'd21, 9'd3, 9'd22, 9'd3}) begin
      nerr++;
      $display("FAIL flush operands: st=%b dvd0=%0d dvs0=%0d dvd1=%0d dvs1=%0d want 1 21 3 22 3",
               ds0, dvd0, dvs0, dvd1, dvs1);
    end
    wait_avg(n);
    nvec++;
    if ({av0, ad0, ac0, ad1, ac1} !== {1'b1, 9'd7, 4'd3, 9'd7, 4'd3}) begin
      nerr++;
      $display("FAIL flush avg: av=%b ad0=%0d ac0=%0d ad1=%0d ac1=%0d want 1 7 3 7 3",
               av0, ad0, ac0, ad1, ac1);
    end
    ack();
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if ({bsy0, ds0, bsy1, ds1, srdy0} !== 5'b00001) begin
        nerr++;
        $display("FAIL empty flush cyc%0d: busy=%b start=%b rdy=%b want 0 0 1",
                 i, bsy0, ds0, srdy0);
      end
      tick();
    end
  endtask

  task automatic test_idle_gap();
    int n;
    dmode = 1;
    n = 0;
    while (!drdy && n < 40) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    push(6'd1);
    push(6'd2);
    push(6'd3);
    push(6'd4);
    n = 0;
    while (!drdy && n < 40) begin
      nvec++;
      if ({ds0, ds1, dvd0, dvs0, dvd1} !== {1'b1, 1'b1, 9'd10, 9'd4, 9'd12}) begin
        nerr++;
        $display("FAIL launch hold cyc%0d: st=%b dvd0=%0d dvs0=%0d dvd1=%0d want 1 10 4 12",
                 n, ds0, dvd0, dvs0, dvd1);
      end
      tick();
      n++;
    end
    nvec++;
    if (!drdy || !ds0) begin
      nerr++;
      $display("FAIL gap pulse: ready=%b start=%b after %0d cycles, want 1 1", drdy, ds0, n);
    end
    wait_avg(n);
    nvec++;
    if (n !== 11) begin
      nerr++;
      $display("FAIL gap latency: %0d edges from pulse, want 11", n);
    end
    nvec++;
    if ({ad0, ad1, ac0} !== {9'd2, 9'd3, 4'd4}) begin
      nerr++;
      $display("FAIL gap avg: ad0=%0d ad1=%0d ac=%0d want 2 3 4", ad0, ad1, ac0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if ({av0, srdy0, ad0, ac0, av1, ad1} !==
          {1'b1, 1'b0, 9'd2, 4'd4, 1'b1, 9'd3}) begin
        nerr++;
        $display("FAIL hold cyc%0d: av=%b rdy=%b ad0=%0d ac=%0d ad1=%0d want 1 0 2 4 3",
                 i, av0, srdy0, ad0, ac0, ad1);
      end
    end
    ack();
  endtask

  task automatic test_timeout();
    int n;
    dmode = 2;
    tick();
    tick();
    push(6'd12);
    push(6'd12);
    push(6'd12);
    push(6'd12);
    for (int i = 0; i < 48; i++) tick();
    nvec++;
    if ({err0, bsy0, ds0} !== 3'b011) begin
      nerr++;
      $display("FAIL pre-timeout: err=%b busy=%b start=%b want 0 1 1", err0, bsy0, ds0);
    end
    tick();
    nvec++;
    if ({err0, err1, srdy0, bsy0, av0, ds0} !== 6'b111000) begin
      nerr++;
      $display("FAIL timeout: err=%b/%b rdy=%b busy=%b av=%b st=%b want 1 1 1 0 0 0",
               err0, err1, srdy0, bsy0, av0, ds0);
    end
    dmode = 0;
    tick();
    tick();
    push(6'd4);
    push(6'd4);
    push(6'd4);
    push(6'd4);
    nvec++;
    if ({dvd0, dvd1} !== {9'd16, 9'd18}) begin
      nerr++;
      $display("FAIL post-timeout sum: dvd0=%0d dvd1=%0d want 16 18", dvd0, dvd1);
    end
    wait_avg(n);
    nvec++;
    if ({av0, ad0, ad1, ac0, err0} !== {1'b1, 9'd4, 9'd4, 4'd4, 1'b1}) begin
      nerr++;
      $display("FAIL post-timeout avg: av=%b ad0=%0d ad1=%0d ac=%0d err=%b want 1 4 4 4 1",
               av0, ad0, ad1, ac0, err0);
    end
    ack();
  endtask

  task automatic test_reset_busy();
    int n;
    push(6'd30);
    push(6'd30);
    push(6'd30);
    push(6'd30);
    for (int i = 0; i < 4; i++) tick();
    nvec++;
    if ({bsy0, ds0, av0} !== 3'b100) begin
      nerr++;
      $display("FAIL busy pre-reset: busy=%b start=%b av=%b want 1 0 0", bsy0, ds0, av0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if ({srdy0, av0, err0, bsy0, srdy1, err1} !== 6'b100010) begin
      nerr++;
      $display("FAIL reset in busy: rdy=%b av=%b err=%b busy=%b rdy1=%b err1=%b want 1 0 0 0 1 0",
               srdy0, av0, err0, bsy0, srdy1, err1);
    end
    for (int i = 0; i < 12; i++) tick();
    push(6'd8);
    push(6'd8);
    push(6'd8);
    push(6'd10);
    wait_avg(n);
    nvec++;
    if ({av0, ad0, ad1, ac0, ac1} !== {1'b1, 9'd8, 9'd9, 4'd4, 4'd4}) begin
      nerr++;
      $display("FAIL post-reset avg: av=%b ad0=%0d ad1=%0d ac=%0d/%0d want 1 8 9 4 4",
               av0, ad0, ad1, ac0, ac1);
    end
    ack();
  endtask

  initial begin
    rst        = 1'b1;
    samp_valid = 1'b0;
    samp_data  = '0;
    flush      = 1'b0;
    avg_ack    = 1'b0;
    test_reset();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_idle_gap();
    test_timeout();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
